// File: rtl/main_leds_pkg.sv
// main_leds_pkg: register addresses, default widths and the auto-off timer state type
package main_leds_pkg;
  localparam int DATA_W_DEFAULT = 8;
  localparam int TMR_W_DEFAULT = 16;
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_OUTSET = 2'd1;
  localparam logic [1:0] ADDR_OUTCLEAR = 2'd2;
  localparam logic [1:0] ADDR_TIMEOUT = 2'd3;
  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/main_leds_timer.sv
// main_leds_timer: auto-off countdown FSM; load/value start or cancel, abort cancels, expire pulses on the final edge, running/count for readback
module main_leds_timer
  import main_leds_pkg::*;
#(
  parameter int TMR_W = TMR_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             abort,
  input  logic [TMR_W-1:0] value,
  output logic             expire,
  output logic             running,
  output logic [TMR_W-1:0] count
);
  state_t state, state_nx;
  logic [TMR_W-1:0] count_nx;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nx;
      count <= count_nx;
    end
  always_comb begin
    state_nx = state;
    count_nx = count;
    if (abort || (load && value == '0)) begin
      state_nx = IDLE;
      count_nx = '0;
    end else if (load) begin
      state_nx = RUN;
      count_nx = value;
    end else if (state == RUN) begin
      state_nx = count <= TMR_W'(1) ? IDLE : RUN;
      count_nx = count == '0 ? '0 : count - TMR_W'(1);
    end
  end
  always_comb begin
    running = state == RUN;
    expire = running && count == TMR_W'(1) && !load && !abort;
  end
endmodule

// File: rtl/main_leds.sv
// main_leds: Avalon-MM LED port with set/clear and auto-off timer; clk/reset_n, chipselect/write_n/address/writedata in, readdata (registered) and out_port out
module main_leds
  import main_leds_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int TMR_W = TMR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [1:0]        address,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [DATA_W-1:0] out_port
);
  logic [DATA_W-1:0] data_reg, data_nx, wd;
  logic [TMR_W-1:0] timeout_reg, count;
  logic wr, load, abort, expire, running, unused;
  logic [31:0] rd_nx;
  assign unused = ^writedata;
  assign wd = writedata[DATA_W-1:0];
  assign wr = chipselect && !write_n;
  assign load = wr && (address == ADDR_DATA || address == ADDR_OUTSET);
  assign abort = wr && address == ADDR_TIMEOUT;
  assign out_port = data_reg;
  main_leds_timer #(.TMR_W(TMR_W)) u_timer (
    .clk(clk),
    .reset_n(reset_n),
    .load(load),
    .abort(abort),
    .value(timeout_reg),
    .expire(expire),
    .running(running),
    .count(count)
  );
  always_comb begin
    data_nx = !wr ? (expire ? '0 : data_reg) :
              address == ADDR_DATA ? wd :
              address == ADDR_OUTSET ? data_reg | wd :
              address == ADDR_OUTCLEAR ? data_reg & ~wd : data_reg;
    rd_nx = address == ADDR_DATA ? 32'(data_reg) :
            address == ADDR_OUTSET ? 32'(count) :
            address == ADDR_OUTCLEAR ? 32'(running) : 32'(timeout_reg);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      data_reg <= '0;
      timeout_reg <= '0;
      readdata <= '0;
    end else begin
      data_reg <= data_nx;
      timeout_reg <= abort ? writedata[TMR_W-1:0] : timeout_reg;
      readdata <= rd_nx;
    end
endmodule

// File: tb/tb_main_leds.sv
// tb_main_leds: scenario tasks against a behavioural model; expected readdata queued at drive time, popped one edge later
module tb_main_leds;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic chipselect = 1'b0;
  logic write_n = 1'b1;
  logic [1:0] address = 2'd0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0] out_port;
  int total = 0;
  int bad = 0;
  logic [31:0] rdq[$];
  logic [31:0] exp_rd;
  logic [7:0] m_data;
  logic [15:0] m_cnt, m_tmo;
  logic m_run;

  main_leds #(.DATA_W(8), .TMR_W(16)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .chipselect(chipselect),
    .write_n(write_n),
    .address(address),
    .writedata(writedata),
    .readdata(readdata),
    .out_port(out_port)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_data = '0;
    m_cnt = '0;
    m_tmo = '0;
    m_run = 1'b0;
    rdq.delete();
  endtask

  task automatic cyc(input logic cs, input logic wn, input logic [1:0] a, input logic [31:0] wd);
    logic [7:0] n_data;
    logic [15:0] n_cnt, n_tmo;
    logic n_run;
    chipselect = cs;
    write_n = wn;
    address = a;
    writedata = wd;
    rdq.push_back(a == 2'd0 ? {24'b0, m_data} : a == 2'd1 ? {16'b0, m_cnt} :
                  a == 2'd2 ? {31'b0, m_run} : {16'b0, m_tmo});
    n_data = m_data;
    n_cnt = m_cnt;
    n_tmo = m_tmo;
    n_run = m_run;
    if (m_run) begin
      if (m_cnt == 16'd1) begin
        n_cnt = '0;
        n_run = 1'b0;
        n_data = '0;
      end else n_cnt = m_cnt - 16'd1;
    end
    if (cs && !wn) begin
      case (a)
        2'd0: begin n_data = wd[7:0]; n_cnt = m_tmo; n_run = m_tmo != 0; end
        2'd1: begin n_data = m_data | wd[7:0]; n_cnt = m_tmo; n_run = m_tmo != 0; end
        2'd2: n_data = m_data & ~wd[7:0];
        default: begin n_tmo = wd[15:0]; n_cnt = '0; n_run = 1'b0; end
      endcase
    end
    @(posedge clk);
    #1;
    m_data = n_data;
    m_cnt = n_cnt;
    m_tmo = n_tmo;
    m_run = n_run;
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (out_port !== 8'h00) begin bad++; $display("FAIL reset_out: got %h want 00", out_port); end
    total++;
    if (readdata !== 32'h0) begin bad++; $display("FAIL reset_rd: got %h want 0", readdata); end
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_hold();
    cyc(1'b1, 1'b0, 2'd0, 32'h1234_56A5);
    exp_rd = rdq.pop_front();
    total++;
    if (out_port !== 8'hA5) begin bad++; $display("FAIL hold_write: got %h want a5", out_port); end
    for (int i = 0; i < 100; i++) begin
      cyc(1'b0, 1'b1, 2'd0, 32'h0);
      exp_rd = rdq.pop_front();
      total++;
      if (readdata !== exp_rd || readdata !== 32'h0000_00A5) begin
        bad++; $display("FAIL hold_rd[%0d]: got %h want %h", i, readdata, exp_rd);
      end
      total++;
      if (out_port !== 8'hA5) begin bad++; $display("FAIL hold_out[%0d]: got %h want a5", i, out_port); end
    end
  endtask

  task automatic test_set_clear();
    cyc(1'b1, 1'b0, 2'd1, 32'hFFFF_FF0F);
    exp_rd = rdq.pop_front();
    total++;
    if (out_port !== 8'hAF) begin bad++; $display("FAIL outset: got %h want af", out_port); end
    cyc(1'b1, 1'b0, 2'd2, 32'h0000_0081);
    exp_rd = rdq.pop_front();
    total++;
    if (out_port !== 8'h2E) begin bad++; $display("FAIL outclear: got %h want 2e", out_port); end
    cyc(1'b0, 1'b0, 2'd0, 32'h0000_0055);
    exp_rd = rdq.pop_front();
    total++;
    if (out_port !== 8'h2E) begin bad++; $display("FAIL nocs: got %h want 2e", out_port); end
    for (int a = 0; a < 4; a++) begin
      cyc(1'b0, 1'b1, 2'(a), 32'h0);
      exp_rd = rdq.pop_front();
      total++;
      if (readdata !== exp_rd) begin bad++; $display("FAIL sc_rd[%0d]: got %h want %h", a, readdata, exp_rd); end
    end
  endtask

  task automatic test_timeout();
    cyc(1'b1, 1'b0, 2'd3, 32'hABCD_0004);
    exp_rd = rdq.pop_front();
    cyc(1'b1, 1'b0, 2'd0, 32'h0000_003C);
    exp_rd = rdq.pop_front();
    total++;
    if (out_port !== 8'h3C) begin bad++; $display("FAIL to_e0: got %h want 3c", out_port); end
    for (int e = 1; e <= 7; e++) begin
      cyc(1'b0, 1'b1, e[0] ? 2'd2 : 2'd1, 32'h0);
      exp_rd = rdq.pop_front();
      total++;
      if (readdata !== exp_rd) begin bad++; $display("FAIL to_rd[E%0d]: got %h want %h", e, readdata, exp_rd); end
      total++;
      if (out_port !== (e < 4 ? 8'h3C : 8'h00)) begin
        bad++; $display("FAIL to_out[E%0d]: got %h want %h", e, out_port, e < 4 ? 8'h3C : 8'h00);
      end
    end
    cyc(1'b0, 1'b1, 2'd3, 32'h0);
    exp_rd = rdq.pop_front();
    cyc(1'b0, 1'b1, 2'd3, 32'h0);
    exp_rd = rdq.pop_front();
    total++;
    if (readdata !== 32'h4) begin bad++; $display("FAIL to_tmo_rd: got %h want 4", readdata); end
  endtask

  task automatic test_back_to_back();
    cyc(1'b1, 1'b0, 2'd0, 32'h0000_0011);
    exp_rd = rdq.pop_front();
    for (int e = 1; e <= 9; e++) begin
      cyc(e == 4 ? 1'b1 : 1'b0, e == 4 ? 1'b0 : 1'b1, e == 4 ? 2'd1 : 2'd2, 32'h0000_0022);
      exp_rd = rdq.pop_front();
      total++;
      if (readdata !== exp_rd) begin bad++; $display("FAIL b2b_rd[E%0d]: got %h want %h", e, readdata, exp_rd); end
      total++;
      if (out_port !== (e < 4 ? 8'h11 : e < 8 ? 8'h33 : 8'h00)) begin
        bad++; $display("FAIL b2b_out[E%0d]: got %h want %h", e, out_port, e < 4 ? 8'h11 : e < 8 ? 8'h33 : 8'h00);
      end
    end
  endtask

  task automatic test_reset_mid();
    cyc(1'b1, 1'b0, 2'd3, 32'h0000_000A);
    cyc(1'b1, 1'b0, 2'd0, 32'h0000_00FF);
    repeat (3) cyc(1'b0, 1'b1, 2'd1, 32'h0);
    total++;
    if (out_port !== 8'hFF) begin bad++; $display("FAIL rm_pre: got %h want ff", out_port); end
    #2;
    chipselect = 1'b1;
    write_n = 1'b0;
    address = 2'd0;
    writedata = 32'h77;
    reset_n = 1'b0;
    #1;
    total++;
    if (out_port !== 8'h00) begin bad++; $display("FAIL rm_out: got %h want 00", out_port); end
    total++;
    if (readdata !== 32'h0) begin bad++; $display("FAIL rm_rd: got %h want 0", readdata); end
    @(posedge clk);
    #1;
    total++;
    if (out_port !== 8'h00) begin bad++; $display("FAIL rm_nowrite: got %h want 00", out_port); end
    model_reset();
    chipselect = 1'b0;
    write_n = 1'b1;
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, 2'(i), 32'h0);
      exp_rd = rdq.pop_front();
      total++;
      if (readdata !== exp_rd || readdata !== 32'h0) begin bad++; $display("FAIL rm_rd[%0d]: got %h want %h", i, readdata, exp_rd); end
      total++;
      if (out_port !== 8'h00) begin bad++; $display("FAIL rm_idle[%0d]: got %h want 00", i, out_port); end
    end
    cyc(1'b1, 1'b0, 2'd0, 32'h0000_005A);
    exp_rd = rdq.pop_front();
    for (int i = 0; i < 15; i++) begin
      cyc(1'b0, 1'b1, 2'd2, 32'h0);
      exp_rd = rdq.pop_front();
      total++;
      if (readdata !== exp_rd) begin bad++; $display("FAIL rm_run_rd[%0d]: got %h want %h", i, readdata, exp_rd); end
      total++;
      if (out_port !== 8'h5A) begin bad++; $display("FAIL rm_hold[%0d]: got %h want 5a", i, out_port); end
    end
  endtask

  initial begin
    test_reset();
    test_hold();
    test_set_clear();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
